// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (optional MDU_EARLY_OUT_EN multiply early exit)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrt,
    input  logic             loWrt,
    input  logic [WIDTH-1:0] wrtData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [4:0]         r_cnt;

    logic               w_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_dz;
    logic               w_skip_run;
    logic               w_last;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_new_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // op[0]=0 selects the signed variants; 0x80000000 negates to itself and is used as unsigned
    assign w_div   = op[1];
    assign w_a_neg = ~op[0] & srcA[WIDTH-1];
    assign w_b_neg = ~op[0] & srcB[WIDTH-1];
    assign w_abs_a = w_a_neg ? -srcA : srcA;
    assign w_abs_b = w_b_neg ? -srcB : srcB;
    assign w_dz    = w_div && (srcB == '0);

`ifdef MDU_EARLY_OUT_EN
    assign w_skip_run = !w_div && (w_abs_b == '0);
    assign w_last     = (r_cnt == 5'd31) || (!r_is_div && (r_mplr[WIDTH-1:1] == '0));
`else
    assign w_skip_run = 1'b0;
    assign w_last     = (r_cnt == 5'd31);
`endif

    // multiplicand shifts left instead of the product shifting right, so an early exit needs no realignment
    assign w_mul_acc = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

    // divide keeps {remainder, dividend->quotient} in r_acc, divisor in r_mcand[WIDTH-1:0]
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_q_bit     = ~w_div_diff[WIDTH];
    assign w_new_rem   = w_q_bit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

    assign w_prod   = r_neg_res ? -r_acc : r_acc;
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot   = r_acc[WIDTH-1:0];
    assign w_res_hi = r_is_div ? (r_neg_rem ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_neg_res ? -w_quot : w_quot) : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hiWrt) r_hi <= wrtData;
                    if (loWrt) r_lo <= wrtData;
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_is_div  <= w_div;
                        r_neg_res <= !w_dz && (w_a_neg ^ w_b_neg);
                        r_neg_rem <= !w_dz && w_div && w_a_neg;
                        r_mcand   <= {{WIDTH{1'b0}}, (w_div ? w_abs_b : w_abs_a)};
                        r_mplr    <= w_abs_b;
                        // divide by zero preloads the final {HI, LO} so FIXUP passes it straight through
                        if (w_dz)
                            r_acc <= {srcA, {WIDTH{1'b1}}};
                        else if (w_div)
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                        else
                            r_acc <= '0;
                        r_state <= (w_dz || w_skip_run) ? S_FIXUP : S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        r_acc <= {w_new_rem, r_acc[WIDTH-2:0], w_q_bit};
                    end else begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                    end
                    if (w_last) r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (reference model plus directed vectors)
module tb_mult_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hiWrt;
    logic        loWrt;
    logic [31:0] wrtData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hiWrt(hiWrt), .loWrt(loWrt),
        .wrtData(wrtData), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic int run_len(input logic [1:0] o, input logic [31:0] b);
        int n;
        logic [31:0] ab;
        n = 32;
        if (o[1] && b == 32'h0) n = 0;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            ab = (!o[0] && b[31]) ? -b : b;
            n = 0;
            for (int i = 0; i < 32; i++) if (ab[i]) n = i + 1;
        end
`else
        ab = b;
`endif
        return n;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] m_rhi = 32'h0;
    logic [31:0] m_rlo = 32'h0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = 32'h0; m_lo = 32'h0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (m_left == 0) begin
                    m_hi = m_rhi; m_lo = m_rlo; m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                if (hiWrt) m_hi = wrtData;
                if (loWrt) m_lo = wrtData;
                if (start) begin
                    {m_rhi, m_rlo} = ref_result(op, srcA, srcB);
                    m_left = run_len(op, srcB);
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut busy=%b done=%b hi=%h lo=%h want busy=%b done=%b hi=%h lo=%h",
                     $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int cyc0, output int cyc);
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout got=no_done want=done", name);
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int cyc;
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; hiWrt = 1'b0; loWrt = 1'b0;
        srcA = $urandom; srcB = $urandom;
        wait_done(name, 1, cyc);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    endtask

    initial begin
        int cyc;
        start = 1'b0; op = 2'b00; srcA = 32'h0; srcB = 32'h0;
        hiWrt = 1'b0; loWrt = 1'b0; wrtData = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        hiWrt = 1'b1; wrtData = 32'hCAFE_0001;
        @(negedge clk);
        hiWrt = 1'b0; loWrt = 1'b1; wrtData = 32'hBEEF_0002;
        @(negedge clk);
        loWrt = 1'b0;
        chk("mthi", hi, 32'hCAFE_0001);
        chk("mtlo", lo, 32'hBEEF_0002);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
`ifdef MDU_EARLY_OUT_EN
        do_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        do_op("mult_7xm3", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
`else
        do_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        do_op("mult_7xm3", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
`endif
        do_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        hiWrt = 1'b1; loWrt = 1'b1; wrtData = 32'h5555_AAAA;
        do_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        do_op("divu_dz", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 2);
        do_op("div_dz", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 2);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);

        // a second start and an MTHI landing mid-run must both be dropped
        start = 1'b1; op = 2'b01;
`ifdef MDU_EARLY_OUT_EN
        srcA = 32'd1; srcB = 32'd30;
`else
        srcA = 32'd5; srcB = 32'd6;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; srcA = 32'd9; srcB = 32'd3; hiWrt = 1'b1; wrtData = 32'h1234;
        @(negedge clk);
        start = 1'b0; hiWrt = 1'b0;
        wait_done("busy_ignore", 6, cyc);
        chk("busy_ignore_hi", hi, 32'h0);
        chk("busy_ignore_lo", lo, 32'd30);
`ifdef MDU_EARLY_OUT_EN
        chk("busy_ignore_lat", 32'(cyc), 32'd7);
`else
        chk("busy_ignore_lat", 32'(cyc), 32'd34);
`endif

        start = 1'b1; op = 2'b10; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef MDU_EARLY_OUT_EN
        do_op("multu_2x3", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 4);
`else
        do_op("multu_2x3", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 34);
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
